// File: rtl/test_sequencer.sv
// Directed-test sequencer for the adder datapath: loadable program memory, fetch/execute
// stepping, register moves/adds/equality checks, pass/fail reporting and a step watchdog.
module test_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_STEPS  = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load_en,
    input  logic [$clog2(PROG_DEPTH)-1:0] load_addr,
    input  logic [15:0]                   load_data,
    input  logic                          start,
    output logic                          busy,
    output logic                          finished,
    output logic                          success,
    output logic                          timeout,
    output logic [$clog2(PROG_DEPTH)-1:0] ip,
    output logic [7:0]                    fail_count
);

    localparam int AW = $clog2(PROG_DEPTH);
    localparam int SW = $clog2(MAX_STEPS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_MOVI = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_AEQ  = 3'd3;
    localparam logic [2:0] OP_JMP  = 3'd4;
    localparam logic [2:0] OP_BNZ  = 3'd5;

    logic [1:0]                 state_q, state_d;
    logic [15:0]                ir_q, ir_d;
    logic [AW-1:0]              ip_q, ip_d;
    logic [7:0][DATA_WIDTH-1:0] rf_q, rf_d;
    logic [7:0]                 fail_q, fail_d;
    logic [SW-1:0]              steps_q, steps_d;
    logic                       timeout_q, timeout_d;

    logic [15:0] mem_q [PROG_DEPTH];

    logic [2:0]            op, fd, fa, fb;
    logic [7:0]            imm;
    logic [DATA_WIDTH-1:0] ra, rb;
    logic [AW-1:0]         ip_inc;
    logic [SW-1:0]         steps_inc;
    logic                  fail_inc;

    assign op        = ir_q[15:13];
    assign fd        = ir_q[12:10];
    assign fa        = ir_q[9:7];
    assign fb        = ir_q[6:4];
    assign imm       = ir_q[7:0];
    assign ra        = rf_q[fa];
    assign rb        = rf_q[fb];
    assign ip_inc    = ip_q + AW'(1);
    assign steps_inc = steps_q + SW'(1);

    assign busy       = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign finished   = (state_q == S_DONE);
    assign success    = finished && (fail_q == 8'd0) && !timeout_q;
    assign timeout    = timeout_q;
    assign ip         = ip_q;
    assign fail_count = fail_q;

    // Program memory survives reset and start so a program can be rerun without reload.
    always_ff @(posedge clock) begin
        if (load_en && !busy)
            mem_q[load_addr] <= load_data;
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ip_d      = ip_q;
        rf_d      = rf_q;
        fail_d    = fail_q;
        steps_d   = steps_q;
        timeout_d = timeout_q;
        fail_inc  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    ip_d      = '0;
                    rf_d      = '0;
                    fail_d    = 8'd0;
                    steps_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            S_FETCH: begin
                ir_d    = mem_q[ip_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                steps_d = steps_inc;
                ip_d    = ip_inc;
                case (op)
                    OP_HALT: ip_d = ip_q;
                    OP_MOVI: rf_d[fd] = DATA_WIDTH'(imm);
                    OP_ADD:  rf_d[fd] = ra + rb;
                    OP_AEQ:  fail_inc = (ra != rb);
                    OP_JMP:  ip_d = imm[AW-1:0];
                    OP_BNZ:  if (ra != '0) ip_d = imm[AW-1:0];
                    default: fail_inc = 1'b1;
                endcase
                if (fail_inc && fail_q != 8'hFF)
                    fail_d = fail_q + 8'd1;
                // The watchdog step still completes before the run is abandoned.
                if (op == OP_HALT)
                    state_d = S_DONE;
                else if (steps_inc == SW'(MAX_STEPS)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else
                    state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= 16'd0;
            ip_q      <= '0;
            rf_q      <= '0;
            fail_q    <= 8'd0;
            steps_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ip_q      <= ip_d;
            rf_q      <= rf_d;
            fail_q    <= fail_d;
            steps_q   <= steps_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: doc/test_sequencer.md
# test_sequencer

Controller that runs small directed test programs against the adder datapath inside the FPGA test harness. It holds a loadable program memory, steps an instruction pointer through fetch/execute phases, performs register moves, adds and equality assertions, and reports `finished`/`success` for the board-level pass/fail indicator. A watchdog bounds runaway programs.

## Interface
Parameters:
- `PROG_DEPTH`, 16: program memory words; power of two, 2..256.
- `DATA_WIDTH`, 8: register and adder width, 4..32.
- `MAX_STEPS`, 1024: executed-instruction limit before timeout.

Ports:
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `load_en`  in  1  write `load_data` to program word `load_addr`; honoured only when not busy.
- `load_addr`  in  $clog2(PROG_DEPTH)  program write address.
- `load_data`  in  16  instruction word.
- `start`  in  1  single-cycle pulse; begin execution at ip 0.
- `busy`  out  1  high from the cycle after accepted start until finish.
- `finished`  out  1  high once the program halts or times out; held.
- `success`  out  1  valid when `finished`; 1 iff no assertion failed and no timeout.
- `timeout`  out  1  set when `MAX_STEPS` is reached.
- `ip`  out  $clog2(PROG_DEPTH)  current instruction pointer.
- `fail_count`  out  8  number of failed ASSERTEQ, saturating at 255.

## Operation
- Instruction fields: `op`=[15:13], `d`=[12:10], `a`=[9:7], `b`=[6:4], `imm`=[7:0]. Eight registers r0..r7, each `DATA_WIDTH` bits.
- Opcodes: 0 HALT; 1 MOVI rd←imm (zero-extended, or truncated to `DATA_WIDTH`); 2 ADD rd←ra+rb mod 2^DATA_WIDTH, carry discarded; 3 ASSERTEQ: if ra≠rb then fail_count+1 (saturating); 4 JMP ip←imm mod PROG_DEPTH; 5 BNZ: if ra≠0 then ip←imm mod PROG_DEPTH, else ip+1; 6,7 illegal: treated as ASSERTEQ failure, then ip+1.
- Non-branch ip advances by 1 and wraps from PROG_DEPTH-1 to 0.
- FSM: IDLE → (start) FETCH → EXEC → FETCH … ; EXEC of HALT → DONE; step counter reaching MAX_STEPS in EXEC → DONE with timeout=1. DONE → (start) FETCH with fresh run; reset → IDLE from any state.
- FETCH latches program word [ip] into an instruction register; EXEC performs the op and updates ip, registers, counters.
- On accepted start: ip=0, r0..r7=0, fail_count=0, step counter=0, timeout=0, finished=0.
- start while busy ignored. load_en while busy ignored; the program memory is not cleared by reset or start.
- Step counter counts every EXEC including HALT; when the count reaches MAX_STEPS on a non-HALT instruction, that instruction still completes, then DONE with timeout=1.
- success = finished & (fail_count==0) & ~timeout; 0 when not finished.

## Timing
- Reset values: busy=0, finished=0, success=0, timeout=0, ip=0, fail_count=0; state IDLE; registers 0.
- start sampled at edge t → busy=1, state FETCH after t; each instruction takes exactly 2 cycles.
- Program of N instructions ending in HALT: finished=1 and busy=0 after edge t+2N; success is valid in the same cycle.
- Load write visible to a FETCH in the following cycle; load and start in the same cycle while idle: both take effect.
- reset mid-run: next cycle all outputs at reset values; program memory retained.
- fail_count and registers update at the end of EXEC; ip output shows the next instruction after EXEC.

## Test plan
- Load MOVI r1,2; MOVI r2,3; ADD r3,r1,r2; MOVI r4,5; ASSERTEQ r3,r4; HALT; start → finished at start+12 cycles, success=1, fail_count=0.
- Same with MOVI r4,6 → success=0, fail_count=1, timeout=0.
- DATA_WIDTH=8: MOVI 200, MOVI 100, ADD, ASSERTEQ against MOVI 44 → success=1 (wrap mod 256).
- Program `JMP 0` with MAX_STEPS=1024 → finished=1, timeout=1, success=0 after 2048 cycles.
- Countdown loop using ADD with r=255 (−1) and BNZ, 3 iterations, then HALT → correct ip trace, success=1; then restart via start without reload → identical result.
- reset asserted mid-run → all outputs 0 next cycle; load_en during busy leaves program unchanged, verified on the rerun.
